// File: rtl/me_pkg.sv
// me_pkg: shared types and widths for the motion-estimation frame scheduler.
package me_pkg;
  localparam int MB_SIZE = 16;
  localparam int MV_W = 4;
  localparam int SAD_W = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_CAPTURE, S_WAIT_SPACE, S_NEXT, S_DRAIN
  } state_t;
  // Result word is {mb_y, mb_x, motiony, motionx, bestdist}.
  function automatic int res_w(input int mbw);
    return 2 * mbw + 2 * MV_W + SAD_W;
  endfunction
endpackage

// File: rtl/me_frame_scheduler_if.sv
// me_frame_scheduler_if: control, core and result handshake signals of the scheduler.
interface me_frame_scheduler_if import me_pkg::*; #(parameter int MBW = 4) ();
  localparam int RES_W = res_w(MBW);
  logic             start;
  logic             busy;
  logic             done;
  logic             me_start;
  logic [MBW-1:0]   mb_x;
  logic [MBW-1:0]   mb_y;
  logic [MV_W-1:0]  me_motionx;
  logic [MV_W-1:0]  me_motiony;
  logic [SAD_W-1:0] me_bestdist;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  modport master (
    input  start, me_motionx, me_motiony, me_bestdist, res_ready,
    output busy, done, me_start, mb_x, mb_y, res_valid, res_data
  );
  modport slave (
    output start, me_motionx, me_motiony, me_bestdist, res_ready,
    input  busy, done, me_start, mb_x, mb_y, res_valid, res_data
  );
endinterface

// File: rtl/me_result_fifo.sv
// me_result_fifo: small result FIFO; a pop frees space for a push in the same cycle.
module me_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = empty ? '0 : r_mem[r_rp];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/me_frame_scheduler.sv
// me_frame_scheduler: walks the macroblock grid, launches one core search per MB
// and queues the tagged results for a valid/ready consumer.
module me_frame_scheduler import me_pkg::*; #(
  parameter int FRAME_MB_X = 4,
  parameter int FRAME_MB_Y = 4,
  parameter int MBW        = 4,
  parameter int ME_CYCLES  = 4112,
  parameter int FIFO_DEPTH = 2
) (
  input logic             clock,
  input logic             reset_n,
  me_frame_scheduler_if.master bus
);
  localparam int CW    = $clog2(ME_CYCLES);
  localparam int RES_W = res_w(MBW);
  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [MBW-1:0] r_mb_x;
  logic [MBW-1:0] r_mb_y;
  logic           w_full;
  logic           w_empty;
  logic           w_done;
  logic           w_last_x;
  logic           w_last;
  assign w_last_x = r_mb_x == MBW'(FRAME_MB_X - 1);
  assign w_last   = w_last_x && r_mb_y == MBW'(FRAME_MB_Y - 1);
  assign w_done   = r_state == S_DRAIN && w_empty;
  assign bus.done      = w_done;
  assign bus.busy      = r_state != S_IDLE && !w_done;
  assign bus.me_start  = r_state == S_LAUNCH;
  assign bus.mb_x      = r_mb_x;
  assign bus.mb_y      = r_mb_y;
  assign bus.res_valid = !w_empty;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = bus.start ? S_LAUNCH : S_IDLE;
      S_LAUNCH:     w_next = S_RUN;
      S_RUN:        if (r_cnt == '0) w_next = w_full ? S_WAIT_SPACE : S_CAPTURE;
      S_WAIT_SPACE: if (!w_full) w_next = S_CAPTURE;
      S_CAPTURE:    w_next = S_NEXT;
      S_NEXT:       w_next = w_last ? S_DRAIN : S_LAUNCH;
      S_DRAIN:      if (w_empty) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mb_x  <= '0;
      r_mb_y  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LAUNCH) r_cnt <= CW'(ME_CYCLES - 1);
      else if (r_state == S_RUN && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_IDLE && bus.start) begin
        r_mb_x <= '0;
        r_mb_y <= '0;
      end else if (r_state == S_NEXT && !w_last) begin
        r_mb_x <= w_last_x ? '0 : r_mb_x + 1'b1;
        r_mb_y <= w_last_x ? r_mb_y + 1'b1 : r_mb_y;
      end
    end
  end
  me_result_fifo #(.DEPTH(FIFO_DEPTH), .W(RES_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (r_state == S_CAPTURE),
    .pop     (bus.res_valid & bus.res_ready),
    .din     ({r_mb_y, r_mb_x, bus.me_motiony, bus.me_motionx, bus.me_bestdist}),
    .full    (w_full),
    .empty   (w_empty),
    .dout    (bus.res_data)
  );
endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb_me_frame_scheduler: scoreboard bench for a 2x2 frame scheduler plus a 1x1 instance.
module tb_me_frame_scheduler;
  import me_pkg::*;
  localparam int MBW = 4;
  localparam int MEC = 8;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  me_frame_scheduler_if #(.MBW(MBW)) a_if ();
  me_frame_scheduler_if #(.MBW(MBW)) b_if ();
  me_frame_scheduler #(.FRAME_MB_X(2), .FRAME_MB_Y(2), .MBW(MBW), .ME_CYCLES(MEC), .FIFO_DEPTH(2))
    dut_a (.clock(clk), .reset_n(rst_n), .bus(a_if));
  me_frame_scheduler #(.FRAME_MB_X(1), .FRAME_MB_Y(1), .MBW(MBW), .ME_CYCLES(MEC), .FIFO_DEPTH(2))
    dut_b (.clock(clk), .reset_n(rst_n), .bus(b_if));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int n_launch = 0;
  int n_pop = 0;
  int n_done = 0;
  int b_done = 0;
  int n0;
  bit chk_time = 0;
  logic [3:0] ex = 0;
  logic [3:0] ey = 0;
  logic [23:0] exp_q [$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Core stub answers each launch with values derived from the bench's own raster position.
  always @(negedge clk) if (rst_n) begin
    if (a_if.me_start) begin
      if (chk_time) check("me_start_cycle", cyc - t0, 1 + 11 * n_launch);
      check("launch_mb", {a_if.mb_y, a_if.mb_x}, {ey, ex});
      a_if.me_motionx = ex + 4'd3;
      a_if.me_motiony = ey ^ 4'hA;
      a_if.me_bestdist = {ex, ey} + 8'h21;
      exp_q.push_back({ey, ex, ey ^ 4'hA, ex + 4'd3, {ex, ey} + 8'h21});
      n_launch++;
      if (ex == 4'd1) begin
        ex = 0;
        ey = ey + 1;
      end else ex = ex + 1;
    end
    if (a_if.res_valid && a_if.res_ready) begin
      if (exp_q.size() == 0) check("spurious_result", 1, 0);
      else check("res_data", a_if.res_data, exp_q.pop_front());
      n_pop++;
    end
    if (a_if.done) begin
      n_done++;
      check("busy_at_done", a_if.busy, 0);
      check("queue_empty_at_done", exp_q.size(), 0);
      if (chk_time) check("done_cycle", cyc - t0, 45);
    end
  end
  always @(negedge clk) if (rst_n && b_if.done) b_done++;
  task automatic start_frame();
    @(posedge clk);
    #1;
    a_if.start = 1;
    t0 = cyc;
    n_launch = 0;
    n_pop = 0;
    ex = 0;
    ey = 0;
    @(posedge clk);
    #1;
    a_if.start = 0;
  endtask
  task automatic goto_rel(input int r);
    while (cyc - t0 < r) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int lim);
    int d0 = n_done;
    for (int i = 0; i < lim && n_done == d0; i++) @(posedge clk);
    check("done_seen", n_done > d0, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    a_if.start = 0; a_if.res_ready = 1;
    a_if.me_motionx = 0; a_if.me_motiony = 0; a_if.me_bestdist = 0;
    b_if.start = 0; b_if.res_ready = 0;
    b_if.me_motionx = 4'hF; b_if.me_motiony = 4'h0; b_if.me_bestdist = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_me_start", a_if.me_start, 0);
    check("rst_res_valid", a_if.res_valid, 0);
    check("rst_res_data", a_if.res_data, 0);
    check("rst_mb", {a_if.mb_y, a_if.mb_x}, 0);
    rst_n = 1;
    // Free-flowing frame with a stray start during RUN.
    chk_time = 1;
    start_frame();
    goto_rel(5);
    a_if.start = 1;
    @(posedge clk);
    #1;
    a_if.start = 0;
    check("mb_after_stray_start", {a_if.mb_y, a_if.mb_x}, 0);
    check("busy_in_run", a_if.busy, 1);
    wait_done(200);
    check("frame1_pops", n_pop, 4);
    check("frame1_launches", n_launch, 4);
    chk_time = 0;
    // Consumer stalled: scheduler must park once the FIFO is full.
    a_if.res_ready = 0;
    start_frame();
    goto_rel(60);
    check("wait_space_state", dut_a.r_state, S_WAIT_SPACE);
    check("launches_before_stall", n_launch, 3);
    check("valid_while_full", a_if.res_valid, 1);
    repeat (20) @(posedge clk);
    #1;
    check("no_launch_while_full", n_launch, 3);
    check("no_pops_while_stalled", n_pop, 0);
    a_if.res_ready = 1;
    wait_done(200);
    check("frame2_pops", n_pop, 4);
    // Randomly throttled consumer.
    start_frame();
    n0 = n_done;
    for (int i = 0; i < 400 && n_done == n0; i++) begin
      a_if.res_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("frame3_done", n_done - n0, 1);
    check("frame3_pops", n_pop, 4);
    // Asynchronous reset in the middle of MB (1,0).
    a_if.res_ready = 0;
    start_frame();
    goto_rel(17);
    check("cnt_before_reset", dut_a.r_cnt, 3);
    check("mb_before_reset", {a_if.mb_y, a_if.mb_x}, {4'd0, 4'd1});
    n0 = n_done;
    #2 rst_n = 0;
    #1;
    check("mid_rst_busy", a_if.busy, 0);
    check("mid_rst_me_start", a_if.me_start, 0);
    check("mid_rst_mb", {a_if.mb_y, a_if.mb_x}, 0);
    check("mid_rst_res_valid", a_if.res_valid, 0);
    check("mid_rst_res_data", a_if.res_data, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    a_if.res_ready = 1;
    check("no_done_on_reset", n_done, n0);
    chk_time = 1;
    start_frame();
    wait_done(200);
    check("frame4_pops", n_pop, 4);
    chk_time = 0;
    // Single-MB frame: done must wait for the consumer's pop.
    @(posedge clk);
    #1;
    b_if.start = 1;
    @(posedge clk);
    #1;
    b_if.start = 0;
    repeat (30) @(posedge clk);
    #1;
    check("b_res_valid", b_if.res_valid, 1);
    check("b_res_data", b_if.res_data, 32'h000FFF);
    check("b_busy_before_pop", b_if.busy, 1);
    check("b_no_done_before_pop", b_done, 0);
    b_if.res_ready = 1;
    @(posedge clk);
    #1;
    b_if.res_ready = 0;
    check("b_done_after_pop", b_if.done, 1);
    check("b_empty_after_pop", b_if.res_valid, 0);
    @(posedge clk);
    #1;
    check("b_done_one_cycle", b_if.done, 0);
    check("b_idle", b_if.busy, 0);
    check("b_done_count", b_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
